ifetch_prefetch_queue: RTL and testbench

Instruction prefetch queue between the instruction memory port and the ifetch stage. It issues sequential fetch requests ahead of the pipeline and buffers returned {pc, inst} pairs in a small FIFO. Ifetch pops entries with a valid/ready handshake. A redirect from ID (taken branch or jump) flushes the queue, discards in-flight responses and restarts fetch at the new target.

---
 rtl/ifetch_prefetch_queue_pkg.sv | 26 ++
 rtl/ifetch_prefetch_queue_fifo.sv | 70 +++++++
 rtl/ifetch_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_prefetch_queue_pkg.sv
// ifetch_prefetch_queue_pkg
// Shared constants and types for the instruction prefetch queue.
//   ILEN / XLEN      : instruction and address widths
//   DEFAULT_RESET_PC : first fetch address after reset
//   NOP_INST         : encoding ifetch substitutes while valid_o is low
//   fetch_entry_t    : one buffered {pc, inst} pair
//   align_pc()       : force a fetch address onto a 4-byte boundary
// No ports (package).
package ifetch_prefetch_queue_pkg;

    localparam int ILEN = 32;
    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_prefetch_queue_fifo.sv
// prefetch_fifo
// Circular buffer of {pc, inst} entries for the prefetch queue.
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   push, wdata  : write wdata at the tail
//   pop          : drop the head entry
//   flush        : empty the buffer (wins over push/pop)
//   count        : number of stored entries, 0..DEPTH
//   head         : entry at the head (stale when count is 0)
module prefetch_fifo
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && !flush && count == CNT_W'(DEPTH)));

    pop_when_empty: assert property (@(posedge clock) disable iff (reset)
        !(pop && !flush && count == '0));

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// ifetch_prefetch_queue
// Issues sequential instruction fetches ahead of ifetch and buffers the
// returned {pc, inst} pairs. A redirect flushes the buffer, drops every
// in-flight response and restarts fetch at the new target.
// Optional macro PREFETCH_BYPASS_EN: when the buffer is empty, a fresh
// response is presented on valid_o/inst_o/pc_o in the same cycle.
// Ports:
//   clock, reset        : core clock, asynchronous active-high reset
//   redirect_i          : flush and restart at redirect_pc_i
//   redirect_pc_i       : new fetch target (low two bits ignored)
//   imem_req_o/addr_o   : fetch request and its 4-byte-aligned address
//   imem_gnt_i          : request accepted
//   imem_rvalid_i/rdata : in-order response and instruction word
//   valid_o/inst_o/pc_o : head entry towards ifetch
//   ready_i             : ifetch takes the head
module ifetch_prefetch_queue
    import ifetch_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   sum_t;
    localparam sum_t DEPTH_LIM = sum_t'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    cnt_t            outstanding;
    cnt_t            discard;
    cnt_t            count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            grant;
    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_valid;

    assign fifo_valid = (count != '0);

    // Credits: a request is only issued while every outstanding response
    // is guaranteed a free slot, so the response side never stalls.
    assign imem_req_o  = !reset && !redirect_i &&
                         ((sum_t'(count) + sum_t'(outstanding)) < DEPTH_LIM);
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // A response is kept only if it is not owed to an earlier redirect
    // and not overtaken by a redirect in this very cycle.
    assign accept     = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign push_entry = '{pc: resp_pc, inst: imem_rdata_i};
    assign pop        = fifo_valid && ready_i && !redirect_i;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    // Empty buffer: hand the response straight to ifetch, store it only if not taken.
    assign bypass  = accept && !fifo_valid;
    assign push    = accept && !(bypass && ready_i);
    assign valid_o = fifo_valid || bypass;
    assign inst_o  = bypass ? imem_rdata_i : head.inst;
    assign pc_o    = bypass ? resp_pc      : head.pc;
`else
    assign push    = accept;
    assign valid_o = fifo_valid;
    assign inst_o  = head.inst;
    assign pc_o    = head.pc;
`endif

    // Fetch/response pc and credit counters. On redirect every request
    // still in flight (minus one returning now) becomes a discard.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= align_pc(redirect_pc_i);
            resp_pc     <= align_pc(redirect_pc_i);
            outstanding <= outstanding - cnt_t'(imem_rvalid_i);
            discard     <= outstanding - cnt_t'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (accept) begin
                resp_pc <= resp_pc + 64'd4;
            end
            if (imem_rvalid_i && discard != '0) begin
                discard <= discard - 1'b1;
            end
            outstanding <= outstanding + cnt_t'(grant) - cnt_t'(imem_rvalid_i);
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (push_entry),
        .count (count),
        .head  (head)
    );

    rvalid_without_request: assert property (@(posedge clock) disable iff (reset)
        !(imem_rvalid_i && outstanding == '0));

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// tb_ifetch_prefetch_queue
// Directed bench for ifetch_prefetch_queue (DEPTH=4, default build).
// A small in-order memory model grants and answers one cycle after each
// grant with inst = ~addr[31:0]; pops and issued addresses are logged and
// compared against hand-computed pc sequences.
module tb_ifetch_prefetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic        ready_i;

    int          pass_count  = 0;
    int          check_count = 0;
    logic        mem_resp_en;
    logic [63:0] pending [$];
    logic [63:0] issued [$];
    logic [63:0] popped_pc [$];
    logic [31:0] popped_inst [$];

    always #5 clock = ~clock;

    ifetch_prefetch_queue dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .ready_i       (ready_i)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic gnt, input logic ready,
                                 input logic redirect, input logic [63:0] target);
        imem_gnt_i    = gnt;
        ready_i       = ready;
        redirect_i    = redirect;
        redirect_pc_i = target;
        #1;
    endtask

    // One clock: log what the DUT does at the edge, then advance the memory model.
    task automatic tick();
        logic        fire;
        logic        delivered;
        logic [63:0] fire_addr;
        fire      = imem_req_o && imem_gnt_i;
        fire_addr = imem_addr_o;
        delivered = imem_rvalid_i;
        if (valid_o && ready_i && !redirect_i) begin
            popped_pc.push_back(pc_o);
            popped_inst.push_back(inst_o);
        end
        @(posedge clock);
        #1;
        if (delivered && pending.size() > 0) pending.delete(0);
        if (fire) begin
            pending.push_back(fire_addr);
            issued.push_back(fire_addr);
        end
        if (mem_resp_en && pending.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~pending[0][31:0];
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
        #1;
    endtask

    task automatic clearModel();
        pending.delete();
        issued.delete();
        popped_pc.delete();
        popped_inst.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
    endtask

    task automatic startReset();
        reset       = 1'b1;
        mem_resp_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        tick();
        clearModel();
        reset = 1'b0;
        #1;
    endtask

    function automatic logic [63:0] popped_at(input int k);
        return (k < popped_pc.size()) ? popped_pc[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] inst_at(input int k);
        return (k < popped_inst.size()) ? {32'd0, popped_inst[k]} : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [63:0] issued_at(input int k);
        return (k < issued.size()) ? issued[k] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        // Reset state
        reset         = 1'b1;
        mem_resp_en   = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        #1;
        checkOutput("reset_valid", 64'(valid_o), 64'd0);
        checkOutput("reset_req", 64'(imem_req_o), 64'd0);
        checkOutput("reset_pc_o", pc_o, 64'd0);
        checkOutput("reset_inst_o", 64'(inst_o), 64'd0);
        checkOutput("reset_addr", imem_addr_o, 64'h8000_0000);
        tick();
        tick();
        clearModel();
        reset = 1'b0;
        #1;

        // Streaming with gnt=1, ready=1
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("stream_req", 64'(imem_req_o), 64'd1);
        checkOutput("stream_addr0", imem_addr_o, 64'h8000_0000);
        repeat (10) tick();
        checkOutput("stream_pop_count", 64'(popped_pc.size()), 64'd8);
        checkOutput("stream_pop0", popped_at(0), 64'h8000_0000);
        checkOutput("stream_pop1", popped_at(1), 64'h8000_0004);
        checkOutput("stream_pop5", popped_at(5), 64'h8000_0014);
        checkOutput("stream_inst2", inst_at(2), 64'h7FFF_FFF7);
        checkOutput("stream_issue9", issued_at(9), 64'h8000_0024);

        // Stalled ifetch fills exactly DEPTH entries
        startReset();
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        repeat (8) tick();
        checkOutput("stall_grants", 64'(issued.size()), 64'd4);
        checkOutput("stall_req_off", 64'(imem_req_o), 64'd0);
        checkOutput("stall_valid", 64'(valid_o), 64'd1);
        checkOutput("stall_pc_hold", pc_o, 64'h8000_0000);
        checkOutput("stall_inst_hold", 64'(inst_o), 64'h7FFF_FFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("stall_full_req", 64'(imem_req_o), 64'd0);
        repeat (4) tick();
        checkOutput("stall_pops", 64'(popped_pc.size()), 64'd4);
        checkOutput("stall_pop3", popped_at(3), 64'h8000_000C);
        checkOutput("stall_resume", issued_at(4), 64'h8000_0010);

        // Redirect with two requests in flight
        startReset();
        mem_resp_en = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h8000_0100);
        checkOutput("redir_no_req", 64'(imem_req_o), 64'd0);
        tick();
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("redir_valid", 64'(valid_o), 64'd0);
        checkOutput("redir_req", 64'(imem_req_o), 64'd1);
        checkOutput("redir_addr", imem_addr_o, 64'h8000_0100);
        repeat (8) tick();
        checkOutput("redir_pops", 64'(popped_pc.size()), 64'd4);
        checkOutput("redir_pop0", popped_at(0), 64'h8000_0100);
        checkOutput("redir_pop1", popped_at(1), 64'h8000_0104);
        checkOutput("redir_inst0", inst_at(0), 64'h7FFF_FEFF);

        // Redirect coinciding with rvalid, then a second redirect
        startReset();
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h8000_0180);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0202);
        checkOutput("b2b_valid", 64'(valid_o), 64'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        checkOutput("b2b_valid2", 64'(valid_o), 64'd0);
        checkOutput("b2b_addr", imem_addr_o, 64'h0000_0000_0000_0200);
        repeat (6) tick();
        checkOutput("b2b_pops", 64'(popped_pc.size()), 64'd4);
        checkOutput("b2b_pop0", popped_at(0), 64'h0000_0000_0000_0200);
        checkOutput("b2b_pop1", popped_at(1), 64'h0000_0000_0000_0204);

        // Push and pop together at count = DEPTH-1
        startReset();
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        repeat (4) tick();
        checkOutput("pp_req_off", 64'(imem_req_o), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        tick();
        checkOutput("pp_head", pc_o, 64'h8000_0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        checkOutput("pp_req_on", 64'(imem_req_o), 64'd1);
        checkOutput("pp_addr", imem_addr_o, 64'h8000_0010);
        tick();
        tick();
        checkOutput("pp_full_req", 64'(imem_req_o), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'd0);
        repeat (4) tick();
        checkOutput("pp_pops", 64'(popped_pc.size()), 64'd5);
        checkOutput("pp_pop3", popped_at(3), 64'h8000_000C);
        checkOutput("pp_pop4", popped_at(4), 64'h8000_0010);

        // Reset mid-stream: 3 entries stored, 1 outstanding
        startReset();
        mem_resp_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
        repeat (4) tick();
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 64'(valid_o), 64'd0);
        checkOutput("mid_reset_req", 64'(imem_req_o), 64'd0);
        checkOutput("mid_reset_pc_o", pc_o, 64'd0);
        tick();
        clearModel();
        reset = 1'b0;
        #1;
        checkOutput("post_reset_req", 64'(imem_req_o), 64'd1);
        checkOutput("post_reset_addr", imem_addr_o, 64'h8000_0000);
        tick();
        checkOutput("post_reset_issue", issued_at(0), 64'h8000_0000);
        checkOutput("post_reset_valid", 64'(valid_o), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
